// File: rtl/b_risc_pkg.sv
// Shared register-file geometry and the ID/EX bundle for the operand-fetch stage.
// Pure declarations: no latency and no handshake of their own.
// Both the stage and its scoreboard import these widths.
package b_risc_pkg;

    localparam int REG_W     = 32;
    localparam int REG_COUNT = 32;
    localparam int REG_IDX_W = $clog2(REG_COUNT);
    localparam int INFO_W    = 32;

    localparam logic [REG_IDX_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [REG_W-1:0]     rs1_data;
        logic [REG_W-1:0]     rs2_data;
        logic [REG_IDX_W-1:0] rd;
        logic                 rd_wr;
        logic [INFO_W-1:0]    info;
    } id_ex_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-write tracker with combinational RAW/WAW hazard detection.
// Latency: hazards are combinational; pending bits update on the next clk edge.
// Backpressure: none of its own; the stage stalls on its hazard outputs.
import b_risc_pkg::*;

module reg_scoreboard #(
    parameter int REG_COUNT = b_risc_pkg::REG_COUNT,
    parameter int REG_IDX_W = $clog2(REG_COUNT)
) (
    input  logic                 clk,
    input  logic                 aresetn,
    input  logic                 set_en,
    input  logic [REG_IDX_W-1:0] set_idx,
    input  logic                 clr_en,
    input  logic [REG_IDX_W-1:0] clr_idx,
    input  logic                 fclr_en,
    input  logic [REG_IDX_W-1:0] fclr_idx,
    input  logic [REG_IDX_W-1:0] rs1,
    input  logic [REG_IDX_W-1:0] rs2,
    input  logic [REG_IDX_W-1:0] rd,
    input  logic                 rd_wr,
    output logic                 raw,
    output logic                 waw
);

    logic [REG_COUNT-1:0] pending;
    logic [REG_COUNT-1:0] pend_nxt;
    logic [REG_COUNT-1:0] eff_pending;

    // Set is applied last so an issue racing a writeback on the same register wins.
    always_comb begin
        pend_nxt = pending;
        if (clr_en)
            pend_nxt[clr_idx] = 1'b0;
        if (fclr_en)
            pend_nxt[fclr_idx] = 1'b0;
        if (set_en && set_idx != ZERO_REG)
            pend_nxt[set_idx] = 1'b1;
        pend_nxt[0] = 1'b0;
    end

`ifdef OPERAND_FETCH_BYPASS_EN
    logic [REG_COUNT-1:0] clr_vec;

    always_comb begin
        clr_vec = '0;
        for (int i = 0; i < REG_COUNT; i++)
            clr_vec[i] = clr_en && (clr_idx == i[REG_IDX_W-1:0]);
        eff_pending = pending & ~clr_vec;
    end
`else
    assign eff_pending = pending;
`endif

    assign raw = ((rs1 != ZERO_REG) && eff_pending[rs1]) ||
                 ((rs2 != ZERO_REG) && eff_pending[rs2]);
    assign waw = rd_wr && eff_pending[rd];

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn)
            pending <= '0;
        else
            pending <= pend_nxt;
    end

endmodule

// File: rtl/operand_fetch.sv
// Issue stage: reads register_file, bypasses same-cycle writeback, stalls on RAW/WAW via scoreboard.
// Latency: one cycle from accept to out_valid. Optional macro: OPERAND_FETCH_BYPASS_EN.
// Backpressure: in_ready drops while the output is held, on a hazard, or during flush.
import b_risc_pkg::*;

module operand_fetch #(
    parameter int REG_W     = b_risc_pkg::REG_W,
    parameter int REG_COUNT = b_risc_pkg::REG_COUNT,
    parameter int INFO_W    = b_risc_pkg::INFO_W,
    parameter int REG_IDX_W = $clog2(REG_COUNT)
) (
    input  logic                 clk,
    input  logic                 aresetn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [REG_IDX_W-1:0] in_rs1,
    input  logic [REG_IDX_W-1:0] in_rs2,
    input  logic [REG_IDX_W-1:0] in_rd,
    input  logic                 in_rd_wr,
    input  logic [INFO_W-1:0]    in_info,
    output logic [REG_IDX_W-1:0] rd_reg_a,
    output logic [REG_IDX_W-1:0] rd_reg_b,
    input  logic [REG_W-1:0]     rd_data_a,
    input  logic [REG_W-1:0]     rd_data_b,
    input  logic                 wr_en,
    input  logic [REG_IDX_W-1:0] wr_reg,
    input  logic [REG_W-1:0]     wr_data,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [REG_W-1:0]     out_rs1_data,
    output logic [REG_W-1:0]     out_rs2_data,
    output logic [REG_IDX_W-1:0] out_rd,
    output logic                 out_rd_wr,
    output logic [INFO_W-1:0]    out_info
);

    logic   raw;
    logic   waw;
    logic   hazard;
    logic   accept;
    logic   fclr_en;
    id_ex_t ex_q;
    id_ex_t ex_d;
    logic   ex_vld;

    assign rd_reg_a = in_rs1;
    assign rd_reg_b = in_rs2;

`ifdef OPERAND_FETCH_BYPASS_EN
    function automatic logic [REG_W-1:0] sel_operand(input logic [REG_IDX_W-1:0] src,
                                                     input logic [REG_W-1:0]     rf_data);
        if (src == ZERO_REG)
            return '0;
        if (wr_en && wr_reg == src)
            return wr_data;
        return rf_data;
    endfunction
`else
    logic unused_wr_data;
    assign unused_wr_data = ^wr_data;

    function automatic logic [REG_W-1:0] sel_operand(input logic [REG_IDX_W-1:0] src,
                                                     input logic [REG_W-1:0]     rf_data);
        return (src == ZERO_REG) ? '0 : rf_data;
    endfunction
`endif

    assign hazard   = raw | waw;
    assign in_ready = (~ex_vld | out_ready) & ~hazard & ~flush;
    assign accept   = in_valid & in_ready;

    // A flushed writer never reaches writeback, so its pending bit is released here.
    assign fclr_en  = flush & ex_vld & ex_q.rd_wr;

    always_comb begin
        ex_d          = '0;
        ex_d.rs1_data = sel_operand(in_rs1, rd_data_a);
        ex_d.rs2_data = sel_operand(in_rs2, rd_data_b);
        ex_d.rd       = in_rd;
        ex_d.rd_wr    = in_rd_wr;
        ex_d.info     = in_info;
    end

    reg_scoreboard #(
        .REG_COUNT (REG_COUNT),
        .REG_IDX_W (REG_IDX_W)
    ) u_sb (
        .clk      (clk),
        .aresetn  (aresetn),
        .set_en   (accept & in_rd_wr),
        .set_idx  (in_rd),
        .clr_en   (wr_en),
        .clr_idx  (wr_reg),
        .fclr_en  (fclr_en),
        .fclr_idx (ex_q.rd),
        .rs1      (in_rs1),
        .rs2      (in_rs2),
        .rd       (in_rd),
        .rd_wr    (in_rd_wr),
        .raw      (raw),
        .waw      (waw)
    );

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            ex_vld <= 1'b0;
            ex_q   <= '0;
        end else if (accept) begin
            ex_vld <= 1'b1;
            ex_q   <= ex_d;
        end else if (out_ready || flush) begin
            ex_vld <= 1'b0;
        end
    end

    assign out_valid    = ex_vld;
    assign out_rs1_data = ex_q.rs1_data;
    assign out_rs2_data = ex_q.rs2_data;
    assign out_rd       = ex_q.rd;
    assign out_rd_wr    = ex_q.rd_wr;
    assign out_info     = ex_q.info;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: vector table, directed hazard/flush/reset sequences,
// and a queue scoreboard comparing every instruction that leaves the stage.
module tb_operand_fetch;

`ifdef OPERAND_FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        aresetn;
    logic        in_valid, in_ready;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic        in_rd_wr;
    logic [31:0] in_info;
    logic [4:0]  rd_reg_a, rd_reg_b;
    logic [31:0] rd_data_a, rd_data_b;
    logic        wr_en;
    logic [4:0]  wr_reg;
    logic [31:0] wr_data;
    logic        flush;
    logic        out_valid, out_ready;
    logic [31:0] out_rs1_data, out_rs2_data;
    logic [4:0]  out_rd;
    logic        out_rd_wr;
    logic [31:0] out_info;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    operand_fetch dut (
        .clk(clk), .aresetn(aresetn),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_wr(in_rd_wr), .in_info(in_info),
        .rd_reg_a(rd_reg_a), .rd_reg_b(rd_reg_b), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
        .out_rd(out_rd), .out_rd_wr(out_rd_wr), .out_info(out_info)
    );

    // Register file model: combinational read, commit on the clock edge.
    logic [31:0] rf [32];
    assign rd_data_a = rf[rd_reg_a];
    assign rd_data_b = rf[rd_reg_b];
    always @(posedge clk) if (wr_en) rf[wr_reg] <= wr_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] exp_op(input logic [4:0] s);
        if (s == 5'd0) return 32'h0;
        if (BYP && wr_en && wr_reg == s) return wr_data;
        return rf[s];
    endfunction

    typedef struct {
        logic [31:0] a, b;
        logic [4:0]  rd;
        logic        rd_wr;
        logic [31:0] info;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    always @(negedge clk) begin
        if (aresetn) begin
            if (out_valid && flush) begin
                if (sb_q.size() != 0) void'(sb_q.pop_front());
            end else if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected", 1, 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("sb_rs1", out_rs1_data, mon_e.a);
                    chk("sb_rs2", out_rs2_data, mon_e.b);
                    chk("sb_fields", {out_rd, out_rd_wr, out_info}, {mon_e.rd, mon_e.rd_wr, mon_e.info});
                end
            end
            if (in_valid && in_ready)
                sb_q.push_back('{exp_op(in_rs1), exp_op(in_rs2), in_rd, in_rd_wr, in_info});
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic rdw, input logic [31:0] info);
        in_valid = 1'b1; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_rd_wr = rdw; in_info = info;
    endtask

    // Waits (bounded) for in_ready at a negedge, then lets the accept edge pass.
    task automatic wait_ready(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 16);
        if (!in_ready) chk(name, 0, 1);
        step();
    endtask

    // A lone source read of r stalls exactly when r is pending.
    task automatic probe(input logic [4:0] r, input logic exp_pend, input string name);
        in_valid = 1'b0; in_rs1 = r; in_rs2 = 5'd0; in_rd_wr = 1'b0;
        wr_en = 1'b0; flush = 1'b0; out_ready = 1'b1;
        #1;
        chk(name, in_ready, !exp_pend);
        step();
    endtask

    typedef struct {
        logic [4:0]  rs1, rs2, rd;
        logic        rdw;
        logic [31:0] info, exp_a, exp_b;
    } vec_t;
    vec_t tbl [8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'hA000 + i;
        rf[3] = 32'h11; rf[4] = 32'h22;
        tbl[0] = '{5'd1,  5'd2,  5'd10, 1'b1, 32'h300, 32'hA001, 32'hA002};
        tbl[1] = '{5'd0,  5'd20, 5'd11, 1'b1, 32'h301, 32'h0,    32'hA014};
        tbl[2] = '{5'd3,  5'd0,  5'd0,  1'b1, 32'h302, 32'h11,   32'h0};
        tbl[3] = '{5'd21, 5'd21, 5'd12, 1'b0, 32'h303, 32'hA015, 32'hA015};
        tbl[4] = '{5'd31, 5'd4,  5'd13, 1'b1, 32'h304, 32'hA01F, 32'h22};
        tbl[5] = '{5'd5,  5'd30, 5'd14, 1'b0, 32'h305, 32'hDEAD, 32'hA01E};
        tbl[6] = '{5'd0,  5'd0,  5'd15, 1'b0, 32'h306, 32'h0,    32'h0};
        tbl[7] = '{5'd22, 5'd1,  5'd31, 1'b1, 32'h307, 32'hA016, 32'hA001};

        aresetn = 1'b0; wr_en = 1'b0; wr_reg = 5'd0; wr_data = 32'h0;
        flush = 1'b0; out_ready = 1'b1;
        drive(5'd7, 5'd9, 5'd5, 1'b1, 32'hFF);

        // Reset state with decode presenting an instruction
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_rd_reg_a", rd_reg_a, 7);
        chk("rst_rd_reg_b", rd_reg_b, 9);
        chk("rst_out_data", {out_rs1_data, out_rs2_data}, 0);
        chk("rst_out_fields", {out_rd, out_rd_wr, out_info}, 0);
        #1 in_rs1 = 5'd5; in_rs2 = 5'd9; in_rd_wr = 1'b0; #1;
        chk("rst_no_pending", in_ready, 1);

        // Simple issue right after release
        step();
        aresetn = 1'b1;
        drive(5'd3, 5'd4, 5'd5, 1'b1, 32'h100);
        @(negedge clk);
        chk("first_rdy", in_ready, 1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("issue_valid", out_valid, 1);
        chk("issue_data", {out_rs1_data, out_rs2_data}, {32'h11, 32'h22});
        chk("issue_rd", out_rd, 5);
        step();
        probe(5'd5, 1'b1, "pend5_set");

        // RAW on r5 with writeback in the same cycle
        drive(5'd5, 5'd3, 5'd0, 1'b0, 32'h200);
        wr_en = 1'b1; wr_reg = 5'd5; wr_data = 32'hDEAD;
        @(negedge clk);
        chk("raw_wb_rdy", in_ready, BYP);
        step();
        wr_en = 1'b0;
        if (!BYP) begin
            @(negedge clk);
            chk("raw_next_rdy", in_ready, 1);
            step();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("raw_data", {out_rs1_data, out_rs2_data, out_info}, {32'hDEAD, 32'h11, 32'h200});
        step();

        // Table of independent instructions
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].rdw, tbl[i].info);
            wait_ready("tbl_rdy");
            in_valid = 1'b0;
            @(negedge clk);
            chk("tbl_valid", out_valid, 1);
            chk("tbl_data", {out_rs1_data, out_rs2_data}, {tbl[i].exp_a, tbl[i].exp_b});
            chk("tbl_fields", {out_rd, out_rd_wr, out_info}, {tbl[i].rd, tbl[i].rdw, tbl[i].info});
            step();
        end
        probe(5'd10, 1'b1, "tbl_pend10");
        probe(5'd12, 1'b0, "tbl_pend12");

        // WAW on r7
        drive(5'd0, 5'd0, 5'd7, 1'b1, 32'h400);
        wait_ready("waw_first_rdy");
        drive(5'd0, 5'd0, 5'd7, 1'b1, 32'h401);
        repeat (3) begin
            @(negedge clk);
            chk("waw_stall", in_ready, 0);
            step();
        end
        wr_en = 1'b1; wr_reg = 5'd7; wr_data = 32'h77;
        @(negedge clk);
        chk("waw_wb_rdy", in_ready, BYP);
        step();
        wr_en = 1'b0;
        if (!BYP) begin
            @(negedge clk);
            chk("waw_next_rdy", in_ready, 1);
            step();
        end
        in_valid = 1'b0;
        step();

        // Backpressure: output held for 3 cycles
        out_ready = 1'b0;
        drive(5'd1, 5'd2, 5'd0, 1'b0, 32'h500);
        wait_ready("bp_first_rdy");
        drive(5'd3, 5'd4, 5'd0, 1'b0, 32'h501);
        repeat (3) begin
            @(negedge clk);
            chk("bp_hold", {out_valid, out_info, out_rs1_data}, {1'b1, 32'h500, 32'hA001});
            chk("bp_in_ready", in_ready, 0);
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_rdy", in_ready, 1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_second", out_info, 32'h501);
        step();

        // r0 ignores a writeback to r0; set beats clear on r9
        drive(5'd0, 5'd0, 5'd0, 1'b0, 32'h600);
        wr_en = 1'b1; wr_reg = 5'd0; wr_data = 32'h5;
        @(negedge clk);
        chk("r0_rdy", in_ready, 1);
        step();
        drive(5'd0, 5'd5, 5'd9, 1'b1, 32'h601);
        wr_en = 1'b1; wr_reg = 5'd9; wr_data = 32'h99;
        @(negedge clk);
        chk("r0_operand", out_rs1_data, 0);
        chk("race_rdy", in_ready, 1);
        step();
        wr_en = 1'b0; in_valid = 1'b0;
        probe(5'd9, 1'b1, "race_pend9");

        // Flush of a held writer of r6
        out_ready = 1'b0;
        drive(5'd0, 5'd0, 5'd6, 1'b1, 32'h700);
        wait_ready("flush_first_rdy");
        drive(5'd0, 5'd0, 5'd0, 1'b0, 32'h701);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", in_ready, 0);
        step();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", out_valid, 0);
        step();
        probe(5'd6, 1'b0, "flush_pend6");

        // Asynchronous reset mid-operation
        out_ready = 1'b0;
        drive(5'd0, 5'd0, 5'd12, 1'b1, 32'h800);
        wait_ready("arst_first_rdy");
        in_valid = 1'b0;
        @(negedge clk);
        chk("arst_held", out_valid, 1);
        #2 aresetn = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_info", out_info, 0);
        sb_q.delete();
        step();
        aresetn = 1'b1;
        probe(5'd9, 1'b0, "arst_pend9");
        probe(5'd12, 1'b0, "arst_pend12");

        @(negedge clk);
        chk("sb_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
